mux_8: RTL and testbench

- Registered 8-to-1 multiplexer: selects lane `s` of an 8-lane packed input bus and presents it one clock later on `y`.
- Used as a generic lane/bit selector in datapaths that need a timing-clean, registered select output.
- Carries a valid qualifier alongside the data so downstream logic knows when `y` holds a fresh selection.

---
 rtl/mux_8_pkg.sv | 15 +
 rtl/mux_8_comb.sv | 38 +++
 rtl/mux_8.sv | 68 ++++++
 tb/tb_mux_8.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mux_8_pkg.sv
// -----------------------------------------------------------------------------
// mux_8_pkg
// Shared constants and types for the registered 8-to-1 lane multiplexer.
//   NUM_LANES : number of selectable input lanes
//   SEL_W     : width of the lane select
//   sel_t     : lane select type
// -----------------------------------------------------------------------------
package mux_8_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_8_pkg

// File: rtl/mux_8_comb.sv
// -----------------------------------------------------------------------------
// mux_8_comb
// Purely combinational 8-to-1 lane select. Lane k is din[k*WIDTH +: WIDTH],
// with lane 0 at the LSBs.
// Ports:
//   din  : NUM_LANES*WIDTH packed input lanes
//   s    : lane select, every value 0..7 is legal
//   lane : selected lane
// -----------------------------------------------------------------------------
module mux_8_comb
  import mux_8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]           s,
  output logic [WIDTH-1:0]           lane
);

  // Full decode of all eight select values: there is no out-of-range case,
  // so an unknown select never turns into an X on the output by design.
  always_comb begin
    // NOTE: default assignment first so no path leaves lane unassigned,
    // which would otherwise infer a latch.
    lane = '0;
    unique case (s)
      3'd0: lane = din[0*WIDTH +: WIDTH];
      3'd1: lane = din[1*WIDTH +: WIDTH];
      3'd2: lane = din[2*WIDTH +: WIDTH];
      3'd3: lane = din[3*WIDTH +: WIDTH];
      3'd4: lane = din[4*WIDTH +: WIDTH];
      3'd5: lane = din[5*WIDTH +: WIDTH];
      3'd6: lane = din[6*WIDTH +: WIDTH];
      3'd7: lane = din[7*WIDTH +: WIDTH];
    endcase
  end

endmodule : mux_8_comb

// File: rtl/mux_8.sv
// -----------------------------------------------------------------------------
// mux_8
// Registered 8-to-1 multiplexer with a valid qualifier. When in_valid is high
// on a rising edge the selected lane, the select and a one-cycle valid pulse
// are registered; otherwise data and select hold and out_valid drops.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears y, out_valid, s_q)
//   din       : 8 packed lanes of WIDTH bits, lane 0 at the LSBs
//   s         : lane select 0..7
//   in_valid  : qualifies din/s for capture this cycle
//   y         : registered selected lane
//   out_valid : high for one cycle per accepted selection
//   s_q       : select that produced the current y
// -----------------------------------------------------------------------------
module mux_8
  import mux_8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]           s,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           y,
  output logic                       out_valid,
  output logic [SEL_W-1:0]           s_q
);

  logic [WIDTH-1:0] lane_sel;
  logic [WIDTH-1:0] y_r;
  sel_t             s_r;
  logic             v_r;

  mux_8_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .din  (din),
    .s    (s),
    .lane (lane_sel)
  );

  // Data and select only move on an accepted selection, so later changes on
  // din or s cannot disturb y until the next capture.
  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only a few flops here, all reset asynchronously so the outputs
      // clear without a clock and a pending selection is dropped.
      y_r <= '0;
      s_r <= '0;
      v_r <= 1'b0;
    end else begin
      v_r <= in_valid;
      if (in_valid) begin
        y_r <= lane_sel;
        s_r <= s;
      end
    end
  end

  assign y         = y_r;
  assign s_q       = s_r;
  assign out_valid = v_r;

endmodule : mux_8

// File: tb/tb_mux_8.sv
// -----------------------------------------------------------------------------
// tb_mux_8
// Drives a WIDTH=1 and a WIDTH=8 instance of mux_8 from shared select/valid
// and reset, comparing every output against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mux_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din1;
  logic [63:0] din8;
  logic [2:0]  s;
  logic        in_valid;

  logic        y1;
  logic        ov1;
  logic [2:0]  sq1;
  logic [7:0]  y8;
  logic        ov8;
  logic [2:0]  sq8;

  // Reference model state
  logic        exp_y1;
  logic [7:0]  exp_y8;
  logic [2:0]  exp_s;
  logic        exp_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_8 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .s(s), .in_valid(in_valid),
    .y(y1), .out_valid(ov1), .s_q(sq1)
  );

  mux_8 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .s(s), .in_valid(in_valid),
    .y(y8), .out_valid(ov8), .s_q(sq8)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y1"},  64'(y1),  64'(exp_y1));
    check({tag, ".y8"},  64'(y8),  64'(exp_y8));
    check({tag, ".ov1"}, 64'(ov1), 64'(exp_v));
    check({tag, ".ov8"}, 64'(ov8), 64'(exp_v));
    check({tag, ".sq1"}, 64'(sq1), 64'(exp_s));
    check({tag, ".sq8"}, 64'(sq8), 64'(exp_s));
  endtask

  task automatic model_reset();
    exp_y1 = 1'b0;
    exp_y8 = 8'h00;
    exp_s  = 3'd0;
    exp_v  = 1'b0;
  endtask

  // Apply inputs, take one rising edge, update the model, check 1 ns later.
  task automatic cycle(input string tag, input logic v, input logic [2:0] sel,
                       input logic [7:0] d1, input logic [63:0] d8);
    in_valid = v;
    s        = sel;
    din1     = d1;
    din8     = d8;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (v) begin
      exp_y1 = d1[sel];
      exp_y8 = 8'((d8 >> (int'(sel) * 8)) & 64'hFF);
      exp_s  = sel;
      exp_v  = 1'b1;
    end else begin
      exp_v  = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    s        = 3'd7;
    din1     = 8'hFF;
    din8     = '1;

    // Reset held with active-looking inputs while the clock runs
    for (int i = 0; i < 3; i++) cycle("rst_hold", 1'b1, 3'd7, 8'hFF, '1);
    #3 rst_n = 1'b1;

    // Select sweep: expected lanes 1,1,1,1,0,1,0,1
    for (int i = 0; i < 8; i++)
      cycle("sweep", 1'b1, 3'(i), 8'b1010_1111, 64'h7766554433221100);
    check("sweep_last_y1", 64'(y1), 64'd1);

    // Hold: capture s=4 (y=0), then idle with new din/s
    cycle("hold_cap", 1'b1, 3'd4, 8'b1010_1111, 64'h7766554433221100);
    cycle("hold_idle", 1'b0, 3'd0, 8'hFF, '1);
    cycle("hold_idle", 1'b0, 3'd0, 8'hFF, '1);
    check("hold_sq", 64'(sq1), 64'd4);

    // Wide lanes: s=5 selects 8'h55
    cycle("wide", 1'b1, 3'd5, 8'h00, 64'h7766554433221100);
    check("wide_y8", 64'(y8), 64'h55);

    // Back-to-back with din changing every cycle
    cycle("b2b0", 1'b1, 3'd0, 8'h01, 64'h0);
    cycle("b2b1", 1'b1, 3'd7, 8'h80, 64'h0);
    check("b2b_y1", 64'(y1), 64'd1);

    // Single-cycle valid pulse then idle
    cycle("pulse", 1'b1, 3'd3, 8'h08, 64'h0);
    cycle("pulse_end", 1'b0, 3'd3, 8'h00, 64'h0);

    // Mid-stream reset between edges, with a selection pending
    cycle("pre_rst", 1'b1, 3'd2, 8'h04, 64'h0000_0000_00AB_0000);
    in_valid = 1'b1;
    s        = 3'd6;
    din1     = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    cycle("post_rst", 1'b0, 3'd6, 8'hFF, '1);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom),
            8'($urandom), {$urandom, $urandom});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_8
